// File: rtl/seq_div_32.sv
// Multi-cycle restoring divider: one quotient bit per cycle, Q/R registered when DONE rises.
// Define SEQ_DIV_SIGNED_EN to add the SIGNED input and two's-complement sign fix-up.
module seq_div_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] dvs,
`ifdef SEQ_DIV_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div0
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic              div0_q, div0_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;

    logic              sgn;
    logic              dvd_neg, dvs_neg;
    logic [WIDTH-1:0]  dvd_mag, dvs_mag;
    logic [WIDTH:0]    shifted;
    logic [WIDTH+1:0]  trial;
    logic              qbit;
    logic [WIDTH-1:0]  rem_next, quo_next;

`ifdef SEQ_DIV_SIGNED_EN
    assign sgn = is_signed;
`else
    assign sgn = 1'b0;
`endif

    assign dvd_neg = sgn & dvd[WIDTH-1];
    assign dvs_neg = sgn & dvs[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dvd : dvd;
    assign dvs_mag = dvs_neg ? -dvs : dvs;

    // Partial remainder keeps its carry-out bit so divisors with the MSB set still work.
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign trial    = {1'b0, shifted} - {2'b00, dvs_q};
    assign qbit     = ~trial[WIDTH+1];
    assign rem_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next = {quo_q[WIDTH-2:0], qbit};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        div0_d  = div0_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    cnt_d  = '0;
                    div0_d = 1'b0;
                    if (dvs == '0) begin
                        state_d = StDone;
                        q_d     = '1;
                        r_d     = dvd;
                        div0_d  = 1'b1;
                    end else begin
                        state_d = StBusy;
                        rem_d   = '0;
                        quo_d   = dvd_mag;
                        dvs_d   = dvs_mag;
                        negq_d  = dvd_neg ^ dvs_neg;
                        negr_d  = dvd_neg;
                    end
                end
            end
            StBusy: begin
                rem_d = rem_next;
                quo_d = quo_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                    q_d     = negq_q ? -quo_next : quo_next;
                    r_d     = negr_q ? -rem_next : rem_next;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            div0_q  <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            div0_q  <= div0_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    assign busy = (state_q == StBusy);
    assign done = (state_q == StDone);
    assign q    = q_q;
    assign r    = r_q;
    assign div0 = div0_q;

endmodule

// File: tb/tb_seq_div_32.sv
// Directed self-checking bench for seq_div_32: latency, results, divide-by-zero, busy/back-to-back
// and mid-operation reset; signed vectors run only when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_div_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dvd_in;
    logic [31:0] dvs_in;
`ifdef SEQ_DIV_SIGNED_EN
    logic        sgn_in;
`endif
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;
    logic        div0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_div_32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dvd       (dvd_in),
        .dvs       (dvs_in),
`ifdef SEQ_DIV_SIGNED_EN
        .is_signed (sgn_in),
`endif
        .busy      (busy),
        .done      (done),
        .q         (q),
        .r         (r),
        .div0      (div0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of cycle 1.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sg);
        dvd_in = a;
        dvs_in = b;
`ifdef SEQ_DIV_SIGNED_EN
        sgn_in = sg;
`else
        if (sg) $display("note: signed vector skipped in unsigned build");
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int first, output int lat, output int nbusy);
        lat   = first;
        nbusy = 0;
        while (!done && lat < 100) begin
            if (busy) nbusy++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sg, input logic [31:0] eq, input logic [31:0] er,
                           input logic ediv0);
        int lat, nbusy;
        launch(a, b, sg);
        wait_done(1, lat, nbusy);
        check_eq({tag, "_lat"}, lat, (b == 0) ? 32'd1 : 32'd33);
        check_eq({tag, "_nbusy"}, nbusy, (b == 0) ? 32'd0 : 32'd32);
        check_eq({tag, "_q"}, q, eq);
        check_eq({tag, "_r"}, r, er);
        check_eq({tag, "_div0"}, {31'd0, div0}, {31'd0, ediv0});
        @(posedge clk);
        #1;
        check_eq({tag, "_pulse"}, {31'd0, done}, 32'd0);
        check_eq({tag, "_qhold"}, q, eq);
    endtask

    initial begin
        int lat, nbusy, ndone;
        rst_n  = 1'b0;
        start  = 1'b0;
        dvd_in = '0;
        dvs_in = '0;
`ifdef SEQ_DIV_SIGNED_EN
        sgn_in = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_q", q, 32'd0);
        check_eq("rst_r", r, 32'd0);
        check_eq("rst_div0", {31'd0, div0}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_div("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        run_div("div0", 32'hDEADBEEF, 32'd0, 1'b0, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1);
        run_div("max_1", 32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0);
        run_div("u5_9", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0);
        run_div("wide_dvs", 32'hFFFFFFFF, 32'h80000001, 1'b0, 32'd1, 32'h7FFFFFFE, 1'b0);
        run_div("hex", 32'h12345678, 32'h00000100, 1'b0, 32'h00123456, 32'h00000078, 1'b0);
        run_div("u1e6", 32'd1000000, 32'd999, 1'b0, 32'd1001, 32'd1, 1'b0);

        // START during BUSY is ignored.
        launch(32'd50, 32'd5, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        dvd_in = 32'd9;
        dvs_in = 32'd3;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(11, lat, nbusy);
        check_eq("ign_lat", lat, 32'd33);
        check_eq("ign_q", q, 32'd10);
        check_eq("ign_r", r, 32'd0);

        // Back-to-back: START while DONE is high.
        launch(32'd9, 32'd3, 1'b0);
        check_eq("b2b_busy", {31'd0, busy}, 32'd1);
        check_eq("b2b_qhold", q, 32'd10);
        wait_done(1, lat, nbusy);
        check_eq("b2b_lat", lat, 32'd33);
        check_eq("b2b_q", q, 32'd3);
        check_eq("b2b_r", r, 32'd0);
        @(posedge clk);
        #1;

        // Reset mid-operation.
        launch(32'd1000, 32'd3, 1'b0);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check_eq("mid_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_done", {31'd0, done}, 32'd0);
        check_eq("mid_q", q, 32'd0);
        check_eq("mid_r", r, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check_eq("mid_nodone", ndone, 32'd0);
        run_div("after_rst", 32'd77, 32'd7, 1'b0, 32'd11, 32'd0, 1'b0);

`ifdef SEQ_DIV_SIGNED_EN
        run_div("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run_div("s_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0);
        run_div("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0);
        run_div("s_div0", 32'hFFFFFFF9, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
